alu_modport: RTL and testbench
==============================

// Module: alu_modport
// PURPOSE
//  Registered N-bit ALU (arithmetic + logical) driven through the ALU interface modports.
//  Captures operands/command on CLK when CE=1; drives result and status flags one cycle later
//  (multiplies: two cycles). Leaf datapath block in the ALU verification environment.
// PARAMETERS
//  N  8  operand width (OPA/OPB); RES is N+1 bits
//  M  4  command width (CMD)
// PORTS
//  CLK        in   1    clock, rising edge
//  RST        in   1    reset, asynchronous, active-high
//  CE         in   1    clock enable; 0 = hold all state and outputs
//  INP_VALID  in   2    operand valid: bit0=OPA, bit1=OPB (00 none, 01 A, 10 B, 11 both)
//  MODE       in   1    1 = arithmetic, 0 = logical
//  CMD        in   M    operation select
//  CIN        in   1    carry/borrow in (ADD_CIN/SUB_CIN)
//  OPA, OPB   in   N    operands
//  RES        out  N+1  result
//  COUT, OFLOW, ERR, E, G, L  out 1 each  carry, overflow/borrow, error, equal, greater, less
// BEHAVIOUR
//  - Reset (async, RST=1): RES=0 and every flag=0; any pending multiply discarded.
//  - Each accepted op rewrites all outputs; flags not defined for the op are driven 0.
//  - MODE=1: 0 ADD A+B (COUT=RES[N]); 1 SUB A-B (OFLOW=A<B); 2 ADD_CIN A+B+CIN (COUT);
//    3 SUB_CIN A-B-CIN (OFLOW=borrow); 4 INC_A; 5 DEC_A; 6 INC_B; 7 DEC_B (inc: COUT=RES[N];
//    dec of 0: OFLOW=1); 8 CMP: E/G/L from A vs B, RES=0; 9 (A+1)*(B+1); 10 (A<<1)*B.
//  - MODE=0 (result zero-extended to N+1): 0 AND 1 NAND 2 OR 3 NOR 4 XOR 5 XNOR 6 NOT_A 7 NOT_B
//    8 A>>1 9 A<<1 10 B>>1 11 B<<1 12 ROL A by B[log2N-1:0] 13 ROR A by B[log2N-1:0].
//  - ROL/ROR: any OPB bit above [log2N-1] set -> ERR=1, RES=0.
//  - Operand check: single-operand ops (INC/DEC/NOT/shift) need only their operand's valid bit;
//    all others need INP_VALID=11. Missing operand or unlisted CMD -> ERR=1, RES=0.
//  - Arithmetic wraps modulo 2^(N+1); SUB borrow yields two's-complement in RES.
//  - Latency: non-multiply 1 cycle. Multiply 2 cycles: capture cycle, then RES=product[N:0],
//    OFLOW=|product[2N-1:N+1]; outputs hold previous values in between.
//  - A command presented in the cycle after a multiply issue is dropped (busy).
//  - CE=0 freezes all state, including an in-flight multiply, which resumes when CE=1.
// CONFIGURATION
//  ALU_MUL_EN defined: MODE=1 CMD 9/10 multiply as above.
//  Not defined: multiplier logic absent; CMD 9/10 treated as invalid (ERR=1, 1-cycle latency).
// STRUCTURE
//  Package alu_pkg: N/M defaults, arith_cmd_e and logic_cmd_e enums, operand-requirement table.
//  One sub-module alu_mul_stage: 2-stage multiplier with busy flag, instantiated under ALU_MUL_EN.
// TESTING
//  ADD MODE=1 CMD=0 INP_VALID=11 A=200 B=100 -> next cycle RES=9'h12C, COUT=1, ERR=0.
//  SUB A=5 B=10 -> RES=9'h1FB, OFLOW=1; CMP A=B=8'h55 -> E=1 G=0 L=0 RES=0.
//  ROL MODE=0 CMD=12 A=8'h81 B=1 -> RES=9'h003; B=8'h10 -> ERR=1 RES=0.
//  MUL CMD=9 A=3 B=4 -> RES=20 two cycles later; without ALU_MUL_EN -> ERR=1 after 1 cycle.
//  ADD with INP_VALID=01 -> ERR=1; INC_A with INP_VALID=01 A=8'hFF -> RES=9'h100, COUT=1.
//  RST asserted mid-multiply, CE=0 hold -> outputs 0 immediately, no late result; CE=0 keeps RES.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, command encodings, operand-requirement table.
// Define ALU_MUL_EN to make arithmetic CMD 9/10 (multiplies) legal commands.
package alu_pkg;

  localparam int ALU_N = 8;
  localparam int ALU_M = 4;

  typedef enum logic [ALU_M-1:0] {
    A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_A, A_DEC_A, A_INC_B, A_DEC_B,
    A_CMP, A_MUL_INC, A_MUL_SHL
  } arith_cmd_e;

  typedef enum logic [ALU_M-1:0] {
    L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_NOT_A, L_NOT_B,
    L_SHR_A, L_SHL_A, L_SHR_B, L_SHL_B, L_ROL, L_ROR
  } logic_cmd_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] need;   // bit0 = OPA required, bit1 = OPB required
  } op_req_t;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic err;
    logic e;
    logic g;
    logic l;
  } alu_flags_t;

  function automatic op_req_t op_req(input logic mode, input logic [ALU_M-1:0] cmd);
    op_req_t r;
    r.legal = 1'b1;
    r.need  = 2'b11;
    if (mode) begin
      case (arith_cmd_e'(cmd))
        A_INC_A, A_DEC_A: r.need = 2'b01;
        A_INC_B, A_DEC_B: r.need = 2'b10;
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: r.need = 2'b11;
`ifdef ALU_MUL_EN
        A_MUL_INC, A_MUL_SHL: r.need = 2'b11;
`endif
        default: r.legal = 1'b0;
      endcase
    end else begin
      case (logic_cmd_e'(cmd))
        L_NOT_A, L_SHR_A, L_SHL_A: r.need = 2'b01;
        L_NOT_B, L_SHR_B, L_SHL_B: r.need = 2'b10;
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL, L_ROR: r.need = 2'b11;
        default: r.legal = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_stage.sv
// Two-stage multiplier: captures pre-formed factors on start, product is ready the next enabled cycle.
// busy marks that following cycle; ce=0 freezes the captured factors and busy.
module alu_mul_stage #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           start,
  input  logic           shl_mode,
  input  logic [N-1:0]   opa,
  input  logic [N-1:0]   opb,
  output logic           busy,
  output logic [2*N-1:0] prod
);

  logic [N:0] fa_q, fb_q;
  logic [N:0] fa_d, fb_d;
  logic [N:0] one_x;

  assign one_x = {{N{1'b0}}, 1'b1};
  assign fa_d  = shl_mode ? {opa, 1'b0} : ({1'b0, opa} + one_x);
  assign fb_d  = shl_mode ? {1'b0, opb} : ({1'b0, opb} + one_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      fa_q <= '0;
      fb_q <= '0;
    end else if (ce) begin
      if (busy) begin
        busy <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
        fa_q <= fa_d;
        fb_q <= fb_d;
      end
    end
  end

  // Product kept modulo 2^(2N); the top only needs bits [2N-1:0].
  assign prod = {{(N-1){1'b0}}, fa_q} * {{(N-1){1'b0}}, fb_q};

endmodule

// File: rtl/alu_modport.sv
// Registered N-bit ALU, 1-cycle latency; multiplies take 2 cycles and drop the command after them.
// Multiplier present only when ALU_MUL_EN is defined; otherwise arithmetic CMD 9/10 report ERR.
module alu_modport
  import alu_pkg::*;
#(
  parameter int N = ALU_N,
  parameter int M = ALU_M
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic [1:0]   INP_VALID,
  input  logic         MODE,
  input  logic [M-1:0] CMD,
  input  logic         CIN,
  input  logic [N-1:0] OPA,
  input  logic [N-1:0] OPB,
  output logic [N:0]   RES,
  output logic         COUT,
  output logic         OFLOW,
  output logic         ERR,
  output logic         E,
  output logic         G,
  output logic         L
);

  localparam int SW = $clog2(N);
  localparam logic [SW:0] N_IDX = (SW+1)'(N);

  logic [N:0]     a_x, b_x, cin_x, one_x;
  logic [N:0]     nxt_res, res_q;
  logic [N-1:0]   lres;
  logic [2*N-1:0] dbl;
  logic [SW-1:0]  sh;
  logic [SW:0]    rol_idx;
  logic           rot_bad;
  logic           is_mul;
  logic           mul_busy;
  logic [2*N-1:0] mul_prod;
  alu_flags_t     nxt_flg, flg_q, mul_flg;
  op_req_t        req;

  assign a_x     = {1'b0, OPA};
  assign b_x     = {1'b0, OPB};
  assign cin_x   = {{N{1'b0}}, CIN};
  assign one_x   = {{N{1'b0}}, 1'b1};
  assign dbl     = {OPA, OPA};
  assign sh      = OPB[SW-1:0];
  assign rol_idx = N_IDX - {1'b0, sh};
  assign rot_bad = |OPB[N-1:SW];

`ifdef ALU_MUL_EN
  alu_mul_stage #(.N(N)) u_mul (
    .clk      (CLK),
    .rst      (RST),
    .ce       (CE),
    .start    (is_mul & ~mul_busy),
    .shl_mode (arith_cmd_e'(CMD) == A_MUL_SHL),
    .opa      (OPA),
    .opb      (OPB),
    .busy     (mul_busy),
    .prod     (mul_prod)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_prod = '0;
`endif

  always_comb begin
    nxt_res = '0;
    nxt_flg = '0;
    lres    = '0;
    is_mul  = 1'b0;
    mul_flg = '0;
    mul_flg.oflow = |mul_prod[2*N-1:N+1];
    req     = op_req(MODE, CMD);
    if (!req.legal || ((INP_VALID & req.need) != req.need)) begin
      nxt_flg.err = 1'b1;
    end else if (MODE) begin
      case (arith_cmd_e'(CMD))
        A_ADD: begin
          nxt_res      = a_x + b_x;
          nxt_flg.cout = nxt_res[N];
        end
        A_SUB: begin
          nxt_res       = a_x - b_x;
          nxt_flg.oflow = (OPA < OPB);
        end
        A_ADD_CIN: begin
          nxt_res      = a_x + b_x + cin_x;
          nxt_flg.cout = nxt_res[N];
        end
        A_SUB_CIN: begin
          nxt_res       = a_x - b_x - cin_x;
          nxt_flg.oflow = (a_x < (b_x + cin_x));
        end
        A_INC_A: begin
          nxt_res      = a_x + one_x;
          nxt_flg.cout = nxt_res[N];
        end
        A_DEC_A: begin
          nxt_res       = a_x - one_x;
          nxt_flg.oflow = (OPA == '0);
        end
        A_INC_B: begin
          nxt_res      = b_x + one_x;
          nxt_flg.cout = nxt_res[N];
        end
        A_DEC_B: begin
          nxt_res       = b_x - one_x;
          nxt_flg.oflow = (OPB == '0);
        end
        A_CMP: begin
          nxt_flg.e = (OPA == OPB);
          nxt_flg.g = (OPA > OPB);
          nxt_flg.l = (OPA < OPB);
        end
`ifdef ALU_MUL_EN
        A_MUL_INC, A_MUL_SHL: is_mul = 1'b1;
`endif
        default: nxt_flg.err = 1'b1;
      endcase
    end else begin
      case (logic_cmd_e'(CMD))
        L_AND:   lres = OPA & OPB;
        L_NAND:  lres = ~(OPA & OPB);
        L_OR:    lres = OPA | OPB;
        L_NOR:   lres = ~(OPA | OPB);
        L_XOR:   lres = OPA ^ OPB;
        L_XNOR:  lres = ~(OPA ^ OPB);
        L_NOT_A: lres = ~OPA;
        L_NOT_B: lres = ~OPB;
        L_SHR_A: lres = OPA >> 1;
        L_SHL_A: lres = OPA << 1;
        L_SHR_B: lres = OPB >> 1;
        L_SHL_B: lres = OPB << 1;
        // Rotates read a window of {OPA,OPA}; out-of-range amounts are rejected.
        L_ROL: begin
          if (rot_bad) nxt_flg.err = 1'b1;
          else         lres = dbl[rol_idx +: N];
        end
        L_ROR: begin
          if (rot_bad) nxt_flg.err = 1'b1;
          else         lres = dbl[{1'b0, sh} +: N];
        end
        default: nxt_flg.err = 1'b1;
      endcase
      nxt_res = {1'b0, lres};
    end
  end

  // A finishing multiply owns the output cycle; a multiply issue leaves outputs untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (CE) begin
      if (mul_busy) begin
        res_q <= mul_prod[N:0];
        flg_q <= mul_flg;
      end else if (!is_mul) begin
        res_q <= nxt_res;
        flg_q <= nxt_flg;
      end
    end
  end

  assign RES   = res_q;
  assign COUT  = flg_q.cout;
  assign OFLOW = flg_q.oflow;
  assign ERR   = flg_q.err;
  assign E     = flg_q.e;
  assign G     = flg_q.g;
  assign L     = flg_q.l;

endmodule

// File: tb/tb_alu_modport.sv
// Self-checking bench for alu_modport: directed spec cases plus random ops against an arithmetic model.
// Honours ALU_MUL_EN the same way as the design build.
module tb_alu_modport;

  logic       CLK, RST, CE, MODE, CIN;
  logic [1:0] INP_VALID;
  logic [3:0] CMD;
  logic [7:0] OPA, OPB;
  logic [8:0] RES;
  logic       COUT, OFLOW, ERR, E, G, L;

  logic [14:0] obs;
  logic [14:0] exp_q;
  logic [14:0] pend_val;
  bit          pend;
  int          total, bad;

  alu_modport dut (
    .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
    .CMD(CMD), .CIN(CIN), .OPA(OPA), .OPB(OPB), .RES(RES),
    .COUT(COUT), .OFLOW(OFLOW), .ERR(ERR), .E(E), .G(G), .L(L)
  );

  assign obs = {RES, COUT, OFLOW, ERR, E, G, L};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected outputs as {res[8:0], cout, oflow, err, e, g, l}; mul=1 means the value lands a cycle late.
  function automatic logic [14:0] model_op(input bit mode, input int cmd, input bit cin,
                                           input logic [1:0] iv, input int a, input int b,
                                           output bit mul);
    int r, p;
    bit co, ov, er, e, g, l, need_a, need_b, known;
    r = 0; p = 0; co = 0; ov = 0; er = 0; e = 0; g = 0; l = 0; mul = 0;
    need_a = 1; need_b = 1;
    if (mode) begin
      if (cmd == 4 || cmd == 5) need_b = 0;
      if (cmd == 6 || cmd == 7) need_a = 0;
      known = (cmd <= 8);
`ifdef ALU_MUL_EN
      if (cmd == 9 || cmd == 10) known = 1;
`endif
    end else begin
      if (cmd inside {6, 8, 9}) need_b = 0;
      if (cmd inside {7, 10, 11}) need_a = 0;
      known = (cmd <= 13);
    end
    if (!known || (need_a && !iv[0]) || (need_b && !iv[1])) return {9'd0, 6'b001000};
    if (mode) begin
      case (cmd)
        0: begin r = (a + b) % 512; co = (r >= 256); end
        1: begin r = (a - b + 512) % 512; ov = (a < b); end
        2: begin r = (a + b + cin) % 512; co = (r >= 256); end
        3: begin r = (a - b - cin + 1024) % 512; ov = (a < b + cin); end
        4: begin r = (a + 1) % 512; co = (r >= 256); end
        5: begin r = (a + 511) % 512; ov = (a == 0); end
        6: begin r = (b + 1) % 512; co = (r >= 256); end
        7: begin r = (b + 511) % 512; ov = (b == 0); end
        8: begin e = (a == b); g = (a > b); l = (a < b); end
        9: begin p = ((a + 1) * (b + 1)) % 65536; r = p % 512; ov = (p / 512 != 0); mul = 1; end
        default: begin p = (2 * a * b) % 65536; r = p % 512; ov = (p / 512 != 0); mul = 1; end
      endcase
    end else begin
      case (cmd)
        0: r = a & b;
        1: r = 255 & ~(a & b);
        2: r = a | b;
        3: r = 255 & ~(a | b);
        4: r = a ^ b;
        5: r = 255 & ~(a ^ b);
        6: r = 255 & ~a;
        7: r = 255 & ~b;
        8: r = a / 2;
        9: r = (a * 2) % 256;
        10: r = b / 2;
        11: r = (b * 2) % 256;
        12: if (b > 7) er = 1; else r = ((a << b) | (a >> (8 - b))) & 255;
        default: if (b > 7) er = 1; else r = ((a >> b) | (a << (8 - b))) & 255;
      endcase
    end
    return {9'(r), co, ov, er, e, g, l};
  endfunction

  task automatic cycle(input bit ce, input logic [1:0] iv, input bit mode, input int cmd,
                       input bit cin, input int a, input int b);
    logic [14:0] v;
    bit m;
    @(negedge CLK);
    CE = ce; INP_VALID = iv; MODE = mode; CMD = 4'(cmd); CIN = cin;
    OPA = 8'(a); OPB = 8'(b);
    if (ce) begin
      if (pend) begin
        exp_q = pend_val;
        pend  = 0;
      end else begin
        v = model_op(mode, cmd, cin, iv, a, b, m);
        if (m) begin pend = 1; pend_val = v; end
        else exp_q = v;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1; CE = 0; INP_VALID = 0; MODE = 0; CMD = 0; CIN = 0; OPA = 0; OPB = 0;
    exp_q = '0; pend = 0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (obs !== 15'd0) begin
      bad++; $display("FAIL reset_state: got %h want 0", obs);
    end
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_directed;
    cycle(1, 2'b11, 1, 0, 0, 200, 100);
    total++;
    if (RES !== 9'h12C || COUT !== 1'b1 || ERR !== 1'b0 || obs !== exp_q) begin
      bad++; $display("FAIL add_200_100: got %h want res=12c cout=1 (model %h)", obs, exp_q);
    end
    cycle(1, 2'b11, 1, 1, 0, 5, 10);
    total++;
    if (RES !== 9'h1FB || OFLOW !== 1'b1 || obs !== exp_q) begin
      bad++; $display("FAIL sub_borrow: got %h want res=1fb oflow=1 (model %h)", obs, exp_q);
    end
    cycle(1, 2'b11, 1, 8, 0, 8'h55, 8'h55);
    total++;
    if (obs !== {9'd0, 6'b000100}) begin
      bad++; $display("FAIL cmp_equal: got %h want %h", obs, {9'd0, 6'b000100});
    end
    cycle(1, 2'b11, 0, 12, 0, 8'h81, 1);
    total++;
    if (RES !== 9'h003 || ERR !== 1'b0) begin
      bad++; $display("FAIL rol_by_1: got %h want res=003 err=0", obs);
    end
    cycle(1, 2'b11, 0, 12, 0, 8'h81, 8'h10);
    total++;
    if (obs !== {9'd0, 6'b001000}) begin
      bad++; $display("FAIL rol_bad_amount: got %h want err=1 res=0", obs);
    end
    cycle(1, 2'b01, 1, 0, 0, 3, 4);
    total++;
    if (obs !== {9'd0, 6'b001000}) begin
      bad++; $display("FAIL add_missing_b: got %h want err=1 res=0", obs);
    end
    cycle(1, 2'b01, 1, 4, 0, 8'hFF, 0);
    total++;
    if (RES !== 9'h100 || COUT !== 1'b1 || ERR !== 1'b0) begin
      bad++; $display("FAIL inc_a_wrap: got %h want res=100 cout=1", obs);
    end
    cycle(1, 2'b01, 1, 5, 0, 0, 0);
    total++;
    if (RES !== 9'h1FF || OFLOW !== 1'b1) begin
      bad++; $display("FAIL dec_a_zero: got %h want res=1ff oflow=1", obs);
    end
    cycle(1, 2'b10, 0, 7, 0, 0, 8'h0F);
    total++;
    if (obs !== {9'h0F0, 6'b000000}) begin
      bad++; $display("FAIL not_b_only_b: got %h want res=0f0", obs);
    end
    cycle(1, 2'b11, 0, 14, 0, 1, 1);
    total++;
    if (ERR !== 1'b1 || RES !== 9'd0) begin
      bad++; $display("FAIL unlisted_cmd: got %h want err=1 res=0", obs);
    end
  endtask

  task automatic test_mul;
    cycle(1, 2'b11, 1, 0, 0, 1, 1);
    cycle(1, 2'b11, 1, 9, 0, 3, 4);
`ifdef ALU_MUL_EN
    total++;
    if (RES !== 9'd2 || obs !== exp_q) begin
      bad++; $display("FAIL mul_hold: got %h want res=2 (model %h)", obs, exp_q);
    end
    cycle(1, 2'b11, 1, 0, 0, 7, 7);
    total++;
    if (RES !== 9'd20 || ERR !== 1'b0 || obs !== exp_q) begin
      bad++; $display("FAIL mul_result: got %h want res=20 (model %h)", obs, exp_q);
    end
    cycle(1, 2'b11, 1, 0, 0, 7, 7);
    total++;
    if (RES !== 9'd14) begin
      bad++; $display("FAIL after_mul_add: got %h want res=14", obs);
    end
    cycle(1, 2'b11, 1, 9, 0, 3, 4);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 2'b11, 0, 0, 0, 0, 0);
      total++;
      if (RES !== 9'd14 || obs !== exp_q) begin
        bad++; $display("FAIL mul_ce_freeze: got %h want res=14", obs);
      end
    end
    cycle(1, 2'b11, 0, 0, 0, 8'hFF, 8'hFF);
    total++;
    if (RES !== 9'd20 || obs !== exp_q) begin
      bad++; $display("FAIL mul_resume: got %h want res=20", obs);
    end
`else
    total++;
    if (obs !== {9'd0, 6'b001000}) begin
      bad++; $display("FAIL mul_disabled: got %h want err=1 res=0", obs);
    end
`endif
  endtask

  task automatic test_ce_hold;
    cycle(1, 2'b11, 1, 0, 0, 1, 2);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 2'b11, 1, 1, 0, 0, 9);
      total++;
      if (RES !== 9'd3 || obs !== exp_q) begin
        bad++; $display("FAIL ce_hold: got %h want res=3", obs);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    cycle(1, 2'b11, 1, 0, 0, 10, 10);
    cycle(1, 2'b11, 1, 9, 0, 3, 4);
    #2;
    CE = 0;
    RST = 1;
    exp_q = '0; pend = 0;
    #1;
    total++;
    if (obs !== 15'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", obs);
    end
    @(negedge CLK);
    RST = 0;
    cycle(1, 2'b11, 0, 0, 0, 8'hF0, 8'h3C);
    total++;
    if (obs !== {9'h030, 6'b000000}) begin
      bad++; $display("FAIL no_late_result: got %h want res=030", obs);
    end
  endtask

  task automatic test_random;
    int cmd, a, b;
    bit mode, ce;
    logic [1:0] iv;
    for (int i = 0; i < 400; i++) begin
      ce   = ($urandom_range(0, 6) != 0);
      mode = $urandom_range(0, 1);
      cmd  = $urandom_range(0, 15);
      iv   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      a    = $urandom_range(0, 255);
      b    = $urandom_range(0, 255);
      if (!mode && cmd >= 12 && $urandom_range(0, 1)) b = $urandom_range(0, 7);
      cycle(ce, iv, mode, cmd, 1'($urandom_range(0, 1)), a, b);
      total++;
      if (obs !== exp_q) begin
        bad++;
        $display("FAIL random_op%0d: mode=%0d cmd=%0d iv=%b a=%0d b=%0d got %h want %h",
                 i, mode, cmd, iv, a, b, obs, exp_q);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_mul();
    test_ce_hold();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
